mc_seq: RTL and testbench
=========================

MC_SEQ -- requirements
Module: mc_seq

Interface
REQ-001 SHALL: clk  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL: ins  in  32  memory read-data bus; carries the instruction word during fetch.
REQ-004 SHALL: mem_ack  in  1  memory handshake completion; data valid the same cycle.
REQ-005 SHALL: mem_req  out  1  memory access request; held until mem_ack.
REQ-006 SHALL: mem_we  out  1  write qualifier for mem_req (1 = store).
REQ-007 SHALL: ir_wr  out  1  instruction register load strobe.
REQ-008 SHALL: pc_wr  out  1  program counter write strobe.
REQ-009 SHALL: pc_src  out  2  PC source: 00 = pc+4, 01 = branch target, 10 = jump target, 11 = register (jr).
REQ-010 SHALL: br_en  out  1  conditional PC write; the datapath gates it with its compare result.
REQ-011 SHALL: reg_wr  out  1  register-file write strobe.
REQ-012 SHALL: state  out  3  current FSM state encoding.
REQ-013 SHALL: retire  out  1  one-cycle pulse on an instruction's final cycle.
REQ-014 SHALL: instr_cnt  out  32  retired-instruction counter.
REQ-015 SHALL: trap  out  1  illegal-opcode flag; present only with MC_SEQ_TRAP_EN.

Function
REQ-016 SHALL: use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-017 SHALL: in FETCH, assert mem_req=1 and mem_we=0; stay in FETCH until mem_ack.
REQ-018 SHALL: on the FETCH mem_ack cycle, assert ir_wr=1, pc_wr=1 and pc_src=00; capture ins[31:26] into op_q and ins[5:0] into fn_q; go to DECODE.
REQ-019 SHALL: in DECODE, go to EXEC for legal opcodes. Legal: 000000, 000001, 000010, 000011, 000100-000111, 001000-001111, 100000, 100011, 100100, 101000, 101011.
REQ-020 SHALL: in EXEC, for branches (000001, 000100-000111), assert br_en=1 and pc_src=01, pulse retire, and go to FETCH.
REQ-021 SHALL: in EXEC, for j (000010), assert pc_wr=1 and pc_src=10; for jal (000011), additionally assert reg_wr=1; retire and go to FETCH.
REQ-022 SHALL: in EXEC, for R-type with fn_q=001000 (jr), assert pc_wr=1 and pc_src=11, retire, and go to FETCH.
REQ-023 SHALL: in EXEC, go to WB for other R-type and immediate-ALU (001xxx) instructions; go to MEM for loads and stores.
REQ-024 SHALL: in MEM, assert mem_req=1, with mem_we=1 for stores (101xxx); stay in MEM until mem_ack.
REQ-025 SHALL: on MEM mem_ack, go to WB for a load; for a store, retire and go to FETCH.
REQ-026 SHALL: in WB, assert reg_wr=1 for exactly one cycle, retire, and go to FETCH.
REQ-027 SHALL: latency without wait states: branch/jump 3 cycles, ALU 4, store 4, load 5; each mem_ack wait cycle adds one.
REQ-028 SHALL: decode all outputs combinationally from state, op_q and fn_q; strobes not named for a state are 0.
REQ-029 SHALL: increment instr_cnt by 1 on each retire; wrap from 0xFFFFFFFF to 0.
REQ-030 SHALL: ignore mem_ack outside FETCH and MEM.
REQ-031 SHALL: never assert mem_req and reg_wr in the same cycle.

Reset
REQ-032 SHALL: while rst=1, force all outputs to 0, set state to FETCH, and clear op_q, fn_q and instr_cnt; this takes priority over mem_ack.
REQ-033 SHALL: drop mem_req in the same cycle on reset mid-FETCH or mid-MEM; the pending access is abandoned.
REQ-034 SHALL: in the first cycle after rst falls, be in FETCH with mem_req=1.

Configuration
REQ-035 SHALL: with MC_SEQ_TRAP_EN defined, route an illegal opcode in DECODE to TRAP. TRAP holds trap=1, keeps all strobes 0, and is left only by rst.
REQ-036 SHALL: without MC_SEQ_TRAP_EN, treat an illegal opcode as a NOP: retire in DECODE and go to FETCH; the trap port is absent.

Verification
REQ-037 SHALL: rst 2 cycles, then mem_ack=1 with ins=0x8C080004 (lw) -> states 0,1,2,3,4; reg_wr=1 in cycle 5 only; instr_cnt=1.
REQ-038 SHALL: fetch of ins=0xAC080004 (sw) with mem_ack held 0 for 3 MEM cycles -> mem_req=1 and mem_we=1 for 4 MEM cycles; retire on the ack; reg_wr never asserted.
REQ-039 SHALL: ins=0x10000003 (beq) -> br_en=1 with pc_src=01 in EXEC; retire after 3 cycles; ins=0x0C000010 (jal) -> pc_wr=1, pc_src=10 and reg_wr=1 together.
REQ-040 SHALL: rst asserted mid-MEM -> mem_req=0 the same cycle, state=0 and instr_cnt=0 next cycle.
REQ-041 SHALL: instr_cnt forced to 0xFFFFFFFF plus one retire -> 0; ins=0xFC000000 -> TRAP with trap=1 held (with MC_SEQ_TRAP_EN), or NOP retire in DECODE (without).

Source files
------------

// File: rtl/mc_seq.sv
// mc_seq: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Define MC_SEQ_TRAP_EN to trap illegal opcodes; otherwise they retire as NOPs.
module mc_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic        br_en,
    output logic        reg_wr,
    output logic [2:0]  state,
    output logic        retire,
`ifdef MC_SEQ_TRAP_EN
    output logic [31:0] instr_cnt,
    output logic        trap
`else
    output logic [31:0] instr_cnt
`endif
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t      st_q, st_d;
    logic [5:0]  op_q, fn_q;
    logic [31:0] cnt_q;
    logic        unused_ins;

    assign unused_ins = ^ins[25:6];

    logic is_rtype, is_jr, is_branch, is_j, is_jal, is_imm, is_load, is_store, is_legal;
    assign is_rtype  = (op_q == 6'b000000);
    assign is_jr     = is_rtype && (fn_q == 6'b001000);
    assign is_branch = (op_q == 6'b000001) || (op_q[5:2] == 4'b0001);
    assign is_j      = (op_q == 6'b000010);
    assign is_jal    = (op_q == 6'b000011);
    assign is_imm    = (op_q[5:3] == 3'b001);
    assign is_load   = (op_q == 6'b100000) || (op_q == 6'b100011) || (op_q == 6'b100100);
    assign is_store  = (op_q == 6'b101000) || (op_q == 6'b101011);
    assign is_legal  = is_rtype || is_branch || is_j || is_jal || is_imm || is_load || is_store;

    // Outputs are a pure decode of state/op/fn (plus mem_ack for handshake cycles);
    // reset masks everything so an in-flight request drops the same cycle.
    always_comb begin
        st_d    = st_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        pc_src  = 2'b00;
        br_en   = 1'b0;
        reg_wr  = 1'b0;
        retire  = 1'b0;
        case (st_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                    st_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    st_d = S_EXEC;
                end else begin
`ifdef MC_SEQ_TRAP_EN
                    st_d = S_TRAP;
`else
                    retire = 1'b1;
                    st_d   = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    br_en  = 1'b1;
                    pc_src = 2'b01;
                    retire = 1'b1;
                    st_d   = S_FETCH;
                end else if (is_j || is_jal) begin
                    pc_wr  = 1'b1;
                    pc_src = 2'b10;
                    reg_wr = is_jal;
                    retire = 1'b1;
                    st_d   = S_FETCH;
                end else if (is_jr) begin
                    pc_wr  = 1'b1;
                    pc_src = 2'b11;
                    retire = 1'b1;
                    st_d   = S_FETCH;
                end else if (is_load || is_store) begin
                    st_d = S_MEM;
                end else begin
                    st_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q[5:3] == 3'b101);
                if (mem_ack) begin
                    if (is_store) begin
                        retire = 1'b1;
                        st_d   = S_FETCH;
                    end else begin
                        st_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_wr = 1'b1;
                retire = 1'b1;
                st_d   = S_FETCH;
            end
            S_TRAP:  st_d = S_TRAP;
            default: st_d = S_FETCH;
        endcase
        if (rst) begin
            st_d    = S_FETCH;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_wr   = 1'b0;
            pc_wr   = 1'b0;
            pc_src  = 2'b00;
            br_en   = 1'b0;
            reg_wr  = 1'b0;
            retire  = 1'b0;
        end
    end

    assign state     = rst ? 3'd0 : st_q;
    assign instr_cnt = rst ? 32'd0 : cnt_q;
`ifdef MC_SEQ_TRAP_EN
    assign trap      = !rst && (st_q == S_TRAP);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= S_FETCH;
            op_q  <= 6'd0;
            fn_q  <= 6'd0;
            cnt_q <= 32'd0;
        end else begin
            st_q <= st_d;
            if (ir_wr) begin
                op_q <= ins[31:26];
                fn_q <= ins[5:0];
            end
            if (retire)
                cnt_q <= cnt_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_mc_seq.sv
// tb_mc_seq: randomized per-cycle check of mc_seq against a path-level instruction model.
module tb_mc_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins = 32'd0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, ir_wr, pc_wr, br_en, reg_wr, retire, trap_w;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    localparam int C_BR = 0, C_J = 1, C_JAL = 2, C_JR = 3, C_ALU = 4, C_LD = 5, C_ST = 6, C_ILL = 7;

    always #5 clk = ~clk;

    mc_seq dut (
        .clk(clk), .rst(rst), .ins(ins), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .pc_src(pc_src), .br_en(br_en), .reg_wr(reg_wr), .state(state),
        .retire(retire),
`ifdef MC_SEQ_TRAP_EN
        .instr_cnt(instr_cnt), .trap(trap_w)
`else
        .instr_cnt(instr_cnt)
`endif
    );
`ifndef MC_SEQ_TRAP_EN
    assign trap_w = 1'b0;
`endif

    // Expected per-cycle picture: {state, mem_req, mem_we, ir_wr, pc_wr, pc_src, br_en, reg_wr, retire, trap}
    logic [12:0] exp_q[$];
    int          ack_q[$];   // 0/1 drive value, 2 = don't care (randomized)

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) return (fn == 6'b001000) ? C_JR : C_ALU;
        if (op == 6'b000001 || (op >= 6'b000100 && op <= 6'b000111)) return C_BR;
        if (op == 6'b000010) return C_J;
        if (op == 6'b000011) return C_JAL;
        if (op >= 6'b001000 && op <= 6'b001111) return C_ALU;
        if (op == 6'b100000 || op == 6'b100011 || op == 6'b100100) return C_LD;
        if (op == 6'b101000 || op == 6'b101011) return C_ST;
        return C_ILL;
    endfunction

    function automatic logic [12:0] ev(input int st, input bit req, input bit we, input bit irw,
                                       input bit pcw, input logic [1:0] src, input bit br,
                                       input bit rw, input bit ret);
        return {3'(st), req, we, irw, pcw, src, br, rw, ret, (st == 5)};
    endfunction

    task automatic add(input logic [12:0] v, input int a);
        exp_q.push_back(v);
        ack_q.push_back(a);
    endtask

    function automatic logic [12:0] observe();
        return {state, mem_req, mem_we, ir_wr, pc_wr, pc_src, br_en, reg_wr, retire, trap_w};
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1;
        ins = 32'h8C080004;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({observe(), instr_cnt} !== 45'd0) begin
                errors++;
                $display("FAIL %s_in_reset obs=%h cnt=%h req=0", tag, observe(), instr_cnt);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || mem_req !== 1'b1 || instr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL %s_after_reset state=%0d mem_req=%b cnt=%h req=0,1,0", tag, state, mem_req, instr_cnt);
        end
        exp_cnt = 32'd0;
    endtask

    // Starts with the DUT in FETCH; leaves it idle in FETCH.
    task automatic run_instr(input logic [31:0] word, input int fw, input int mw, input string tag);
        int c;
        logic [12:0] obs;
        exp_q.delete();
        ack_q.delete();
        c = classify(word[31:26], word[5:0]);
        for (int i = 0; i < fw; i++) add(ev(0, 1, 0, 0, 0, 2'b00, 0, 0, 0), 0);
        add(ev(0, 1, 0, 1, 1, 2'b00, 0, 0, 0), 1);
        if (c == C_ILL) begin
`ifdef MC_SEQ_TRAP_EN
            add(ev(1, 0, 0, 0, 0, 2'b00, 0, 0, 0), 2);
            for (int i = 0; i < 3; i++) add(ev(5, 0, 0, 0, 0, 2'b00, 0, 0, 0), 2);
`else
            add(ev(1, 0, 0, 0, 0, 2'b00, 0, 0, 1), 2);
`endif
        end else begin
            add(ev(1, 0, 0, 0, 0, 2'b00, 0, 0, 0), 2);
            case (c)
                C_BR:  add(ev(2, 0, 0, 0, 0, 2'b01, 1, 0, 1), 2);
                C_J:   add(ev(2, 0, 0, 0, 1, 2'b10, 0, 0, 1), 2);
                C_JAL: add(ev(2, 0, 0, 0, 1, 2'b10, 0, 1, 1), 2);
                C_JR:  add(ev(2, 0, 0, 0, 1, 2'b11, 0, 0, 1), 2);
                C_ALU: begin
                    add(ev(2, 0, 0, 0, 0, 2'b00, 0, 0, 0), 2);
                    add(ev(4, 0, 0, 0, 0, 2'b00, 0, 1, 1), 2);
                end
                C_LD: begin
                    add(ev(2, 0, 0, 0, 0, 2'b00, 0, 0, 0), 2);
                    for (int i = 0; i < mw; i++) add(ev(3, 1, 0, 0, 0, 2'b00, 0, 0, 0), 0);
                    add(ev(3, 1, 0, 0, 0, 2'b00, 0, 0, 0), 1);
                    add(ev(4, 0, 0, 0, 0, 2'b00, 0, 1, 1), 2);
                end
                default: begin
                    add(ev(2, 0, 0, 0, 0, 2'b00, 0, 0, 0), 2);
                    for (int i = 0; i < mw; i++) add(ev(3, 1, 1, 0, 0, 2'b00, 0, 0, 0), 0);
                    add(ev(3, 1, 1, 0, 0, 2'b00, 0, 0, 1), 1);
                end
            endcase
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            mem_ack = (ack_q[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(ack_q[i]);
            ins = (exp_q[i][12:10] == 3'd0) ? word : $urandom;
            #1;
            obs = observe();
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_cyc%0d ins=%h obs=%h req=%h", tag, i, word, obs, exp_q[i]);
            end
            if (exp_q[i][1]) exp_cnt = exp_cnt + 32'd1;
        end
`ifdef MC_SEQ_TRAP_EN
        if (c == C_ILL) begin
            do_reset({tag, "_trap"});
            return;
        end
`endif
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_cnt state=%0d cnt=%h req=0,%h", tag, state, instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_load();
        run_instr(32'h8C080004, 0, 0, "lw");
    endtask

    task automatic test_store_wait();
        run_instr(32'hAC080004, 0, 3, "sw_wait");
    endtask

    task automatic test_branch_jump();
        run_instr(32'h10000003, 0, 0, "beq");
        run_instr(32'h0C000010, 1, 0, "jal");
        run_instr(32'h08000020, 0, 0, "j");
        run_instr(32'h03E00008, 2, 0, "jr");
        run_instr(32'h01095020, 0, 0, "add");
        run_instr(32'h21080001, 0, 0, "addi");
    endtask

    task automatic test_random();
        logic [5:0] legal [21] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                   6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                   6'h20, 6'h23, 6'h24, 6'h28, 6'h2B};
        logic [5:0] op, fn;
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal[$urandom_range(0, 20)];
            fn = 6'($urandom);
            if (op == 6'd0 && $urandom_range(0, 2) == 0) fn = 6'b001000;
            run_instr({op, 20'($urandom), fn}, $urandom_range(0, 2), $urandom_range(0, 2), "rand");
        end
    endtask

    task automatic test_reset_mid_mem();
        run_instr(32'h01095020, 0, 0, "pre_rst");
        @(negedge clk); mem_ack = 1'b1; ins = 32'hAC080004;
        @(negedge clk); mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state !== 3'd3 || mem_req !== 1'b1 || instr_cnt !== exp_cnt || exp_cnt == 32'd0) begin
            errors++;
            $display("FAIL mid_mem_pre state=%0d mem_req=%b cnt=%h req=3,1,%h", state, mem_req, instr_cnt, exp_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_mem_drop mem_req=%b mem_we=%b req=0,0", mem_req, mem_we);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || instr_cnt !== 32'd0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_post state=%0d cnt=%h mem_req=%b req=0,0,1", state, instr_cnt, mem_req);
        end
        exp_cnt = 32'd0;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        mem_ack = 1'b0;
        force dut.cnt_q = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.cnt_q;
        #1;
        checks++;
        if (instr_cnt !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL wrap_preload cnt=%h req=ffffffff", instr_cnt);
        end
        exp_cnt = 32'hFFFFFFFF;
        run_instr(32'h10000003, 0, 0, "wrap");
    endtask

    task automatic test_illegal();
        run_instr(32'hFC000000, 0, 0, "illegal");
        run_instr(32'h8C080004, 1, 1, "post_illegal");
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_wait();
        test_branch_jump();
        test_random();
        test_reset_mid_mem();
        test_wrap();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
